// File: rtl/cpu_pkg.sv
// Shared simpleCPU definitions: opcode encodings, the instruction-memory
// state enum and the default boot program used when
// INSTR_MEM_DEFAULT_PROG_EN is defined.
package cpu_pkg;

    // 2-bit opcode field in the top of each instruction word
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    // Instruction memory modes: program download, then fetch-only
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Default boot program: INC, DEC, INC, DEC, ADD[3], ADD[2], ADD[3], ADD[2]
    localparam int DEFAULT_PROG_LEN = 8;
    localparam logic [7:0] DEFAULT_PROG [DEFAULT_PROG_LEN] = '{
        {OP_INC, 6'h03}, {OP_DEC, 6'h02}, {OP_INC, 6'h03}, {OP_DEC, 6'h02},
        {OP_ADD, 6'h03}, {OP_ADD, 6'h02}, {OP_ADD, 6'h03}, {OP_ADD, 6'h02}
    };

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W program storage: one write port, one registered read port.
// With INSTR_MEM_DEFAULT_PROG_EN defined, reset clears the array and writes
// the default program into words 0-7; otherwise contents survive reset.
module instr_mem_array
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write port (and optional default-program load on reset)
    always_ff @(posedge clk) begin
`ifdef INSTR_MEM_DEFAULT_PROG_EN
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            // Later assignments win, so the program overlays the cleared words
            for (int i = 0; i < DEFAULT_PROG_LEN; i++) begin
                mem[i] <= DATA_W'(DEFAULT_PROG[i]);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
`else
        if (we) begin
            mem[waddr] <= wdata;
        end
`endif
    end

    // Registered read port; the caller only enables it for in-range addresses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem.sv
// Loadable instruction memory for the simpleCPU.
// LOAD: program download through ld_*; ld_done locks the memory (-> RUN).
// RUN : rd_req/rd_addr fetch with one-cycle latency.
// Handshake: a request is taken on any rising edge where rd_req=1, ena=1 and
// the block is in RUN; exactly one cycle later rd_valid=1 for one cycle with
// the word (or FILL plus rd_err=1 for addresses >= DEPTH). rd_data is high-Z
// whenever rd_valid=0. busy=1 means requests are being dropped, not queued.
// Optional macro INSTR_MEM_DEFAULT_PROG_EN: reset preloads the default program
// and starts in RUN.
module instr_mem
    import cpu_pkg::*;
#(
    parameter int              DATA_W = 8,
    parameter int              ADDR_W = 6,
    parameter int              DEPTH  = 64,
    parameter logic [DATA_W-1:0] FILL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    output logic              ld_err,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              busy
);

    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("instr_mem: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
    end

`ifdef INSTR_MEM_DEFAULT_PROG_EN
    if (DEPTH < DEFAULT_PROG_LEN) begin : g_bad_prog_depth
        $error("instr_mem: default program needs DEPTH >= 8");
    end
    localparam state_t RST_STATE = ST_RUN;
    localparam logic   RST_BUSY  = 1'b0;
`else
    localparam state_t RST_STATE = ST_LOAD;
    localparam logic   RST_BUSY  = 1'b1;
`endif

    // One extra bit so DEPTH == 2**ADDR_W compares correctly
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic              ld_in_range;
    logic              rd_in_range;
    logic              wr_en;
    logic              rd_fire;
    logic [DATA_W-1:0] arr_rdata;

    assign ld_in_range = {1'b0, ld_addr} < DEPTH_C;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_C;
    assign wr_en       = ld_we && (state == ST_LOAD) && ld_in_range;
    assign rd_fire     = rd_req && ena && (state == ST_RUN);

    instr_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (rd_fire && rd_in_range),
        .raddr (rd_addr),
        .rdata (arr_rdata)
    );

    // Mode FSM with registered handshake and error outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RST_STATE;
            busy     <= RST_BUSY;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            ld_err   <= 1'b0;
        end else begin
            ld_err   <= ld_we && ((state == ST_RUN) || !ld_in_range);
            rd_valid <= rd_fire;
            rd_err   <= rd_fire && !rd_in_range;
            unique case (state)
                ST_LOAD: begin
                    if (ld_done) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= RST_STATE;
                end
            endcase
        end
    end

    // Release the shared bus unless a fetched word is being presented
    assign rd_data = rd_valid ? (rd_err ? FILL : arr_rdata) : {DATA_W{1'bz}};

endmodule

// File: tb/tb_instr_mem.sv
// Bench for instr_mem (DEPTH=40, FILL=00h). Expected fetch responses are
// queued as {rd_err, rd_data} by the driver and popped by a negedge monitor.
module tb_instr_mem;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 40;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_done;
    logic              ld_err;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W:0] exp_q[$];

    instr_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .FILL   (8'h00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_done  (ld_done),
        .ld_err   (ld_err),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .busy     (busy)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DATA_W:0] act,
                         input logic [DATA_W:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic done, input logic exp_err);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        ld_done = done;
        tick();
        ld_we   = 1'b0;
        ld_done = 1'b0;
        check("ld_err_pulse", {8'h00, ld_err}, {8'h00, exp_err});
        tick();
        check("ld_err_clear", {8'h00, ld_err}, 9'h000);
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic err,
                         input logic [DATA_W-1:0] d);
        rd_req  = 1'b1;
        rd_addr = a;
        exp_q.push_back({err, d});
        tick();
        rd_req  = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_valid: got %h expected no word", {rd_err, rd_data});
            end else begin
                logic [DATA_W:0] e;
                e = exp_q.pop_front();
                if ({rd_err, rd_data} !== e) begin
                    n_errors++;
                    $display("FAIL fetch_word: got {err,data}=%h expected %h", {rd_err, rd_data}, e);
                end
            end
        end else begin
            n_checks++;
            if (rd_data !== {DATA_W{1'bz}} || rd_err !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_bus: got data=%h err=%b expected data=zz err=0", rd_data, rd_err);
            end
        end
    end

    // stimulus
    initial begin
        rst_n = 1'b0; ena = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        ld_done = 1'b0; rd_req = 1'b0; rd_addr = '0;
        tick();
        tick();
`ifdef INSTR_MEM_DEFAULT_PROG_EN
        check("reset_busy", {8'h00, busy}, 9'h000);
        rst_n = 1'b1;
        begin
            logic [7:0] prog [8];
            prog = '{8'h43, 8'h82, 8'h43, 8'h82, 8'hC3, 8'hC2, 8'hC3, 8'hC2};
            for (int i = 0; i < 8; i++) fetch(ADDR_W'(i), 1'b0, prog[i]);
        end
        fetch(6'd8, 1'b0, 8'h00);
        tick();
`else
        check("reset_busy",   {8'h00, busy},     9'h001);
        check("reset_valid",  {8'h00, rd_valid}, 9'h000);
        check("reset_ld_err", {8'h00, ld_err},   9'h000);
        rst_n = 1'b1;

        // Requests during LOAD are dropped
        rd_req  = 1'b1;
        rd_addr = 6'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("load_busy", {8'h00, busy}, 9'h001);
        end
        rd_req = 1'b0;

        // Program download, including the last word and an out-of-range write
        load(6'd0,  8'h43, 1'b0, 1'b0);
        load(6'd1,  8'hC2, 1'b0, 1'b0);
        load(6'd39, 8'h5A, 1'b0, 1'b0);
        load(6'd50, 8'hFF, 1'b0, 1'b1);
        check("busy_before_done", {8'h00, busy}, 9'h001);
        // Write in the same cycle as ld_done still lands
        ld_we = 1'b1; ld_addr = 6'd2; ld_data = 8'h81; ld_done = 1'b1;
        tick();
        ld_we = 1'b0; ld_done = 1'b0;
        check("busy_after_done", {8'h00, busy}, 9'h000);

        // Back-to-back fetches, then out-of-range ones returning FILL
        fetch(6'd0,  1'b0, 8'h43);
        fetch(6'd1,  1'b0, 8'hC2);
        fetch(6'd2,  1'b0, 8'h81);
        fetch(6'd39, 1'b0, 8'h5A);
        fetch(6'd45, 1'b1, 8'h00);
        fetch(6'd40, 1'b1, 8'h00);
        tick();

        // Writes in RUN are rejected, ld_done ignored
        load(6'd0, 8'hFF, 1'b1, 1'b1);
        check("run_busy", {8'h00, busy}, 9'h000);
        fetch(6'd0, 1'b0, 8'h43);
        tick();

        // ena=0 blocks requests
        ena = 1'b0; rd_req = 1'b1; rd_addr = 6'd1;
        tick();
        tick();
        ena = 1'b1; rd_req = 1'b0;
        tick();

        // Reset coincident with a request: no word, back to LOAD
        rd_req = 1'b1; rd_addr = 6'd1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_busy",  {8'h00, busy},     9'h001);
        check("rst_valid", {8'h00, rd_valid}, 9'h000);
        tick();
        rd_req = 1'b0;
        // Contents survive reset
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        fetch(6'd0, 1'b0, 8'h43);
        fetch(6'd1, 1'b0, 8'hC2);
        tick();
`endif
        tick();
        tick();
        check("queue_drained", 9'(exp_q.size()), 9'h000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_mem.md
# instr_mem

Parametrised instruction memory for the simpleCPU: a clocked, loadable program store with a request/valid read handshake. It replaces the fixed combinational instruction ROM. A program is downloaded through a write port and locked; the CPU then fetches instruction words one cycle after each request. The read data bus is released (high-Z) whenever no valid word is presented, so the shared CPU data bus keeps working unchanged.

## Interface
- DATA_W, 8: instruction word width (2-bit opcode in [DATA_W-1:DATA_W-2], operand below)
- ADDR_W, 6: address width
- DEPTH, 64: implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W
- FILL, 0: word returned for out-of-range reads

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- ena  in  1  block enable; when 0, rd_req is ignored
- ld_we  in  1  program-load write strobe
- ld_addr  in  ADDR_W  load address
- ld_data  in  DATA_W  load word
- ld_done  in  1  end-of-load pulse; locks memory
- ld_err  out  1  one-cycle pulse: rejected load write
- rd_req  in  1  fetch request
- rd_addr  in  ADDR_W  fetch address
- rd_valid  out  1  rd_data holds a fetched word
- rd_data  out  DATA_W  fetched word; high-Z when rd_valid=0
- rd_err  out  1  qualifies rd_valid: address >= DEPTH
- busy  out  1  1 while in LOAD state (fetches refused)

## Operation
- States: LOAD, RUN. Reset -> LOAD (see Configuration for the alternative).
- LOAD:
  - ld_we=1 with ld_addr < DEPTH writes ld_data.
  - ld_we=1 with ld_addr >= DEPTH: no write; ld_err pulses.
  - rd_req is ignored: no rd_valid, no queueing.
  - ld_done=1 -> RUN next cycle. If ld_we=1 in the same cycle, the write completes first.
- RUN:
  - ld_we=1: no write; ld_err pulses. ld_done is ignored.
  - rd_req=1 and ena=1: capture rd_addr. Next cycle rd_valid=1 and rd_data=mem[rd_addr], or FILL with rd_err=1 if rd_addr >= DEPTH.
  - rd_req=0 or ena=0: next cycle rd_valid=0, rd_err=0, rd_data=Z.
- Back-to-back requests are accepted every cycle, giving one word per cycle.
- The only way back to LOAD is reset.
- Memory contents are not cleared by reset, except as stated under Configuration.
- Reset values: state LOAD, rd_valid=0, rd_err=0, ld_err=0, busy=1, rd_data=Z.

## Timing
- Fetch latency: exactly 1 cycle, from the request edge to the rd_valid edge.
- ld_err: 1 cycle after the offending ld_we; lasts 1 cycle per offending write.
- busy: drops in the cycle after ld_done is sampled. The first fetch is accepted on that same edge.
- Write then read of the same address is only possible across LOAD->RUN, so no read/write collision exists.
- Reset asserted mid-fetch: rd_valid=0 on the next edge and the pending word is discarded.

## Configuration
- INSTR_MEM_DEFAULT_PROG_EN defined:
  - Reset loads the default 8-word program into addresses 0-7 and zeros every other word.
  - Default program: 43h, 82h, 43h, 82h, C3h, C2h, C3h, C2h (INC, DEC, INC, DEC, ADD[3], ADD[2], ADD[3], ADD[2]).
  - Reset state is RUN and busy resets to 0.
  - Requires DEPTH >= 8; elaboration error otherwise.
- Undefined: behaviour is exactly as in Operation; memory is uninitialised after reset.

## Structure
- cpu_pkg holds:
  - opcode constants OP_INC=2'b01, OP_DEC=2'b10, OP_ADD=2'b11;
  - the state enum (ST_LOAD, ST_RUN);
  - the default-program word array.
- One sub-module, instr_mem_array: DEPTH x DATA_W storage with one write port and one registered read port.
- instr_mem keeps the FSM, range checks, error pulses and tri-state output.

## Test plan
- Reset, then rd_req=1 at addr 0 for 3 cycles -> busy=1, rd_valid=0, rd_data=Z throughout.
- Load 43h@0 and C2h@1, pulse ld_done, then fetch 0 and 1 back-to-back -> rd_valid=1 on 2 consecutive cycles with 43h then C2h, rd_err=0.
- DEPTH=40 in RUN, fetch addr 45 -> rd_valid=1, rd_err=1, rd_data=00h; load write to addr 50 during LOAD -> ld_err pulses once, memory unchanged.
- In RUN, ld_we at addr 0 with data FFh -> ld_err pulse; later fetch of 0 still returns 43h.
- ena=0 with rd_req=1 in RUN -> rd_valid stays 0; reset asserted the cycle after a request -> no rd_valid, state LOAD.
- With INSTR_MEM_DEFAULT_PROG_EN: reset, then fetch 0-7 -> busy=0 and words 43h, 82h, 43h, 82h, C3h, C2h, C3h, C2h; fetch 8 -> 00h.
